// File: rtl/counter4_ctrl_if.sv
// Button/preset inputs and counter-control outputs of counter4_ctrl,
// bundled so the block and its environment share one connection point.
interface counter4_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             btn_start;
  logic             btn_stop;
  logic             btn_load;
  logic [WIDTH-1:0] preset;
  logic             s_s;
  logic             l;
  logic [WIDTH-1:0] d;
  logic [1:0]       state;

  modport slave (
    input  btn_start, btn_stop, btn_load, preset,
    output s_s, l, d, state
  );

  modport master (
    output btn_start, btn_stop, btn_load, preset,
    input  s_s, l, d, state
  );
endinterface

// File: rtl/counter4_ctrl.sv
// Control front end for the loadable counter: synchronises and debounces the
// start/stop/load buttons, then runs the IDLE/RUN/PAUSE/LOAD machine.
module counter4_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEB_CYCLES  = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           clr,
  counter4_ctrl_if.slave bus
);
  localparam int CW  = (DEB_CYCLES  < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int LCW = (LOAD_CYCLES < 2) ? 1 : $clog2(LOAD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LOAD  = 2'b11
  } state_t;

  // Bit 0 start, bit 1 stop, bit 2 load
  logic [2:0]    btn_s;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    deb_prev_q;
  logic [2:0]    press_s;
  logic [CW-1:0] cnt_q [0:2];
  logic [CW-1:0] cnt_d [0:2];

  state_t           state_q, state_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             s_s_q, s_s_d;
  logic             l_q, l_d;

  assign btn_s   = {bus.btn_load, bus.btn_stop, bus.btn_start};
  assign press_s = deb_q & ~deb_prev_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = {CW{1'b0}};
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = {CW{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      deb_q      <= 3'b000;
      deb_prev_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_q    <= btn_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Presses with no effect in the current state are simply ignored; load
  // wins over stop, stop over start, and LOAD drops everything.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (press_s[2]) begin
          state_d = ST_LOAD;
        end else if (press_s[0]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (press_s[2]) begin
          state_d = ST_LOAD;
        end else if (press_s[1]) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (press_s[2]) begin
          state_d = ST_LOAD;
        end else if (press_s[1]) begin
          state_d = ST_IDLE;
        end else if (press_s[0]) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_LOAD: begin
        if (lcnt_q == LCW'(LOAD_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      lcnt_d = {LCW{1'b0}};
      d_d    = bus.preset;
    end else begin
      d_d = d_q;
    end
    s_s_d = (state_d == ST_RUN);
    l_d   = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      lcnt_q  <= {LCW{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      s_s_q   <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      d_q     <= d_d;
      s_s_q   <= s_s_d;
      l_q     <= l_d;
    end
  end

  assign bus.s_s   = s_s_q;
  assign bus.l     = l_q;
  assign bus.d     = d_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_counter4_ctrl.sv
// Bench for counter4_ctrl: a window-based button model feeds a queue of
// expected outputs that a negedge monitor compares against the DUT.
module tb_counter4_ctrl;
  localparam int DEB = 4;
  localparam int LC  = 2;

  typedef struct {
    logic [1:0] st;
    logic       s_s;
    logic       l;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   lcount = 0;
  exp_t exp_q[$];

  counter4_ctrl_if #(.WIDTH(8)) bus();

  counter4_ctrl #(.WIDTH(8), .DEB_CYCLES(DEB), .LOAD_CYCLES(LC)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: a button's clean level flips once its raw samples have all
  // disagreed with it for DEB consecutive cycles, seen through two sync flops.
  bit       hist [3][$];
  bit       mdeb [3];
  bit       mdeb_p [3];
  int       mst;
  int       mleft;
  bit [7:0] md;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i] = {};
      repeat (DEB + 1) hist[i].push_back(1'b0);
      mdeb[i]   = 1'b0;
      mdeb_p[i] = 1'b0;
    end
    mst = 0; mleft = 0; md = 8'h00;
  endtask

  task automatic model_edge(input bit [2:0] raw, input bit [7:0] pre);
    bit pr [3];
    bit all;
    for (int i = 0; i < 3; i++) pr[i] = mdeb[i] && !mdeb_p[i];
    for (int i = 0; i < 3; i++) begin
      all = 1'b1;
      for (int k = 2; k <= DEB + 1; k++)
        if (hist[i][hist[i].size() - k] == mdeb[i]) all = 1'b0;
      mdeb_p[i] = mdeb[i];
      if (all) mdeb[i] = !mdeb[i];
      hist[i].push_back(raw[i]);
      void'(hist[i].pop_front());
    end
    if (mst == 3) begin
      mleft--;
      if (mleft == 0) mst = 0;
    end else if (pr[2]) begin
      mst = 3; mleft = LC; md = pre;
    end else if (pr[1] && mst == 1) mst = 2;
    else if (pr[1] && mst == 2) mst = 0;
    else if (pr[0] && (mst == 0 || mst == 2)) mst = 1;
  endtask

  // One clock: apply inputs, let the edge happen, queue what must follow it.
  task automatic step(input bit [2:0] raw, input bit [7:0] pre);
    exp_t e;
    bus.btn_start = raw[0];
    bus.btn_stop  = raw[1];
    bus.btn_load  = raw[2];
    bus.preset    = pre;
    @(posedge clk);
    if (clr) model_reset();
    else model_edge(raw, pre);
    e.st = 2'(mst); e.s_s = (mst == 1); e.l = (mst == 3); e.d = md;
    exp_q.push_back(e);
    #1;
    if (bus.l === 1'b1) lcount++;
  endtask

  task automatic press(input bit [2:0] mask, input int hold, input bit [7:0] pre);
    repeat (hold) step(mask, pre);
    repeat (DEB + 3) step(3'b000, pre);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (bus.state !== e.st || bus.s_s !== e.s_s || bus.l !== e.l || bus.d !== e.d) begin
        n_miss++;
        $display("FAIL scoreboard t=%0t: got st=%0d s_s=%0b l=%0b d=%02h expected st=%0d s_s=%0b l=%0b d=%02h",
                 $time, bus.state, bus.s_s, bus.l, bus.d, e.st, e.s_s, e.l, e.d);
      end
    end
  end

  initial begin
    bit [2:0] m;
    bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_load = 1'b0; bus.preset = 8'h00;
    model_reset();
    repeat (3) step(3'b000, 8'h00);
    clr = 1'b0;
    chk("reset_state", {30'd0, bus.state}, 32'd0);
    chk("reset_d", {24'd0, bus.d}, 32'd0);

    // Start held 10 cycles: enable appears on edge 7 and survives release
    for (int k = 1; k <= 10; k++) begin
      step(3'b001, 8'h00);
      chk("start_latency", {31'd0, bus.s_s}, {31'd0, (k >= 7)});
    end
    repeat (8) step(3'b000, 8'h00);
    chk("start_hold", {31'd0, bus.s_s}, 32'd1);

    press(3'b010, 6, 8'h00);
    chk("run_to_pause", {30'd0, bus.state}, 32'd2);
    chk("pause_s_s", {31'd0, bus.s_s}, 32'd0);
    press(3'b001, 6, 8'h00);
    chk("pause_to_run", {30'd0, bus.state}, 32'd1);
    press(3'b010, 6, 8'h00);
    press(3'b010, 6, 8'h00);
    chk("pause_to_idle", {30'd0, bus.state}, 32'd0);

    step(3'b001, 8'h00); step(3'b000, 8'h00);
    step(3'b001, 8'h00); step(3'b000, 8'h00);
    repeat (10) step(3'b000, 8'h00);
    chk("bounce_idle", {30'd0, bus.state}, 32'd0);

    press(3'b001, 6, 8'h00);
    lcount = 0;
    press(3'b100, 6, 8'hF0);
    chk("load_len", lcount, 32'd2);
    chk("load_d", {24'd0, bus.d}, 32'h0000_00F0);
    chk("load_exit", {30'd0, bus.state}, 32'd0);
    repeat (5) step(3'b000, 8'h0F);
    chk("load_d_hold", {24'd0, bus.d}, 32'h0000_00F0);

    // Coincident start+load, then a start that matures inside LOAD
    lcount = 0;
    press(3'b101, 6, 8'h3C);
    chk("coinc_len", lcount, 32'd2);
    chk("coinc_idle", {30'd0, bus.state}, 32'd0);
    step(3'b100, 8'h5A);
    press(3'b101, 6, 8'h5A);
    chk("drop_idle", {30'd0, bus.state}, 32'd0);
    chk("drop_d", {24'd0, bus.d}, 32'h0000_005A);

    for (int r = 0; r < 40; r++) begin
      m = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 9)) step(m, 8'($urandom));
      repeat ($urandom_range(0, 8)) step(3'b000, 8'($urandom));
    end

    // Asynchronous clear in the middle of activity
    press(3'b100, 6, 8'hA5);
    press(3'b001, 7, 8'h00);
    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("async_state", {30'd0, bus.state}, 32'd0);
    chk("async_s_s", {31'd0, bus.s_s}, 32'd0);
    chk("async_l", {31'd0, bus.l}, 32'd0);
    chk("async_d", {24'd0, bus.d}, 32'd0);
    repeat (2) step(3'b000, 8'h00);
    clr = 1'b0;
    press(3'b001, 6, 8'h00);
    repeat (4) step(3'b000, 8'h00);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
